dm_access_unit: RTL and testbench
=================================

// Module: dm_access_unit
// PURPOSE
//  MEM-stage initiator for the word-organised data memory (DM): 1024 x 32b, sync read, 1-cycle read latency.
//  Accepts byte/half/word load-store requests from the pipeline, issues word reads/writes to DM, and returns responses.
//  Responses are sign/zero-extended load data or a store acknowledge.
//  Sub-word stores use read-modify-write, because DM has no byte enables. Pipeline stalls while req_ready=0.
// PARAMETERS
//  WORD_ADDR_W  10  DM word-index width (DM depth = 2**WORD_ADDR_W).
//  CHECK_RANGE  1   1: byte address above DM range -> error response, no DM access.
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   high only in IDLE; transfer = req_valid & req_ready
//  req_write   in   1   1 = store, 0 = load
//  req_size    in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_signed  in   1   loads: 1 sign-extend, 0 zero-extend
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified
//  resp_valid  out  1   one-cycle pulse per accepted request
//  resp_err    out  1   valid with resp_valid: misaligned, reserved size, or out of range
//  resp_rdata  out  32  load result; 0 for stores and errors
//  mem_addr    out  32  DM word address = {2'b00, addr[31:2]}
//  mem_din     out  32  DM write data
//  mem_we      out  1   DM write enable
//  mem_dout    in   32  DM read data, valid the cycle after mem_addr is presented
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_addr=0; mem_din=0.
//  FSM states: IDLE, RD, CAP, WR, RESP. A request is latched on transfer.
//   IDLE -> RESP: error request. No DM access; resp_err=1.
//   IDLE -> WR: word store. mem_din = wdata.
//   IDLE -> RD: load, or byte/half store.
//   RD: mem_addr stable, mem_we=0. DM samples the address at the end of RD.
//   CAP, load: extract lane from mem_dout, extend, register into resp_rdata; then -> RESP.
//   CAP, sub-word store: merge wdata lane into mem_dout, register into mem_din; then -> WR.
//   WR: mem_we=1 for exactly one cycle, decoded from state. -> RESP.
//   RESP: resp_valid=1 for one cycle; resp_err and resp_rdata held. -> IDLE.
//  Latency in cycles from the transfer cycle to resp_valid:
//   load = 3; word store = 2; sub-word store = 4; error = 1.
//   Back-to-back: the next transfer is accepted in the cycle after RESP.
//  Lanes are little-endian. Byte k = bits[8k+7:8k], k = addr[1:0]. Half = bits[16h+15:16h], h = addr[1].
//  Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
//  Range: with CHECK_RANGE=1, addr[31:WORD_ADDR_W+2] != 0 is an error.
//  Sub-word store: only the addressed lane changes. The other bytes are written back exactly as read in the same transaction.
//  mem_addr and mem_din change only on transfer or in CAP. mem_we is never high outside WR.
//  rst mid-operation: next state IDLE, no response issued.
//   A write whose WR cycle coincides with rst still commits; the pipeline must treat it as done.
//   rst during RD or CAP leaves DM unmodified.
//  req_* inputs are ignored while req_ready=0. The latched copy is used throughout the transaction.
// STRUCTURE
//  Shared package dm_pkg: size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD; FSM state encoding; lane-index helpers.
//  Sub-module dm_lane_align (combinational): extract+extend for loads, merge for stores.
//  FSM and registers stay in dm_access_unit. Bench pairs this unit with DM.
// TESTING
//  1 Word store 0xDEADBEEF @0x10, then LW @0x10.
//    -> mem_we pulses once with mem_addr=4; rdata=0xDEADBEEF 3 cycles after accept; err=0.
//  2 After test 1, SB 0x5A @0x12, then LW @0x10.
//    -> 0xDE5ABEEF; the SB response arrives 4 cycles after accept; exactly one mem_we pulse.
//  3 Preload word 0x000080FF @0x20.
//    -> LB @0x20 signed = 0xFFFFFFFF; LBU @0x20 = 0x000000FF; LH @0x20 signed = 0xFFFF80FF; LHU @0x22 = 0x00000000.
//  4 Errors: LH @0x21, LW @0x22, size=11, SW @0x00001000 (range).
//    -> each: resp_err=1, rdata=0, resp 1 cycle after accept, mem_we never high.
//  5 rst asserted in the RD cycle of an SH @0x30.
//    -> no resp_valid; DM word 12 unchanged; req_ready=1 the cycle after rst.
//  6 Back-to-back: req_valid held high with 8 random requests against a reference model.
//    -> one resp per transfer, in order; req_ready low exactly during each transaction.

Source files
------------

// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared types and helpers for the data-memory access unit:
//               access-size codes, FSM state encoding, lane helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    localparam int c_DATA_W = 32;

    // Bit offset of the addressed lane inside the 32-bit word (little-endian).
    function automatic logic [4:0] lane_shift(input size_e size, input logic [1:0] low);
        logic [4:0] shift;
        case (size)
            SZ_BYTE: shift = {low, 3'b000};
            SZ_HALF: shift = {low[1], 4'b0000};
            default: shift = 5'd0;
        endcase
        return shift;
    endfunction

    // Natural alignment check on the two low address bits.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] low);
        logic bad;
        case (size)
            SZ_HALF: bad = low[0];
            SZ_WORD: bad = |low;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dm_lane_align
// Description : Combinational lane logic. Extracts and extends the addressed
//               byte/half from a DM word for loads, and merges store data into
//               the addressed lane of a DM word for read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_lane_align
    import dm_pkg::*;
(
    input  size_e       size,
    input  logic        is_signed,
    input  logic [1:0]  lane,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  w_shift;
    logic [31:0] w_shifted;
    logic [31:0] w_mask;

    // Shift the addressed lane down for loads; mask it in place for stores.
    always_comb begin
        w_shift   = lane_shift(size, lane);
        w_shifted = mem_word >> w_shift;
        w_mask    = 32'hFFFF_FFFF;
        load_data = w_shifted;
        case (size)
            SZ_BYTE: begin
                w_mask    = 32'h0000_00FF;
                load_data = {{24{is_signed & w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                w_mask    = 32'h0000_FFFF;
                load_data = {{16{is_signed & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: ;
        endcase
        merged = (mem_word & ~(w_mask << w_shift)) | ((wdata & w_mask) << w_shift);
    end

endmodule
`default_nettype wire

// File: rtl/dm_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_unit
// Description : MEM-stage initiator for the word-organised data memory.
//               Handles byte/half/word loads and stores, using
//               read-modify-write for sub-word stores, and returns one
//               response per accepted request.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int WORD_ADDR_W = 10,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_we,
    input  logic [31:0] mem_dout
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_write;
    size_e       r_size;
    logic        r_signed;
    logic [1:0]  r_lane;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_din;

    logic        w_xfer;
    logic        w_range_err;
    logic        w_req_err;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_xfer = req_valid & (r_state == ST_IDLE);

    generate
        if (CHECK_RANGE) begin : g_range_chk
            assign w_range_err = |req_addr[31:WORD_ADDR_W+2];
        end else begin : g_range_off
            assign w_range_err = 1'b0;
        end
    endgenerate

    assign w_req_err = (req_size == SZ_RSVD) | w_range_err
                     | is_misaligned(size_e'(req_size), req_addr[1:0]);

    // Store data is parked in r_mem_din at transfer and doubles as the merge source.
    dm_lane_align u_align (
        .size      (r_size),
        .is_signed (r_signed),
        .lane      (r_lane),
        .mem_word  (mem_dout),
        .wdata     (r_mem_din),
        .load_data (w_load_data),
        .merged    (w_merged)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (w_req_err)                               w_state_nxt = ST_RESP;
                    else if (req_write && (req_size == SZ_WORD)) w_state_nxt = ST_WR;
                    else                                         w_state_nxt = ST_RD;
                end
            end
            ST_RD:   w_state_nxt = ST_CAP;
            ST_CAP:  w_state_nxt = r_write ? ST_WR : ST_RESP;
            ST_WR:   w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the request on transfer; capture load data or merged word in CAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_size     <= SZ_BYTE;
            r_signed   <= 1'b0;
            r_lane     <= 2'b00;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
            r_mem_addr <= 32'd0;
            r_mem_din  <= 32'd0;
        end else if (w_xfer) begin
            r_write    <= req_write;
            r_size     <= size_e'(req_size);
            r_signed   <= req_signed;
            r_lane     <= req_addr[1:0];
            r_err      <= w_req_err;
            r_rdata    <= 32'd0;
            r_mem_addr <= {2'b00, req_addr[31:2]};
            r_mem_din  <= req_wdata;
        end else if (r_state == ST_CAP) begin
            if (r_write) r_mem_din <= w_merged;
            else         r_rdata   <= w_load_data;
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_err   = resp_valid & r_err;
    assign resp_rdata = r_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;
    assign mem_we     = (r_state == ST_WR);

endmodule
`default_nettype wire

// File: tb/tb_dm_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_access_unit
// Description : Directed self-checking bench for dm_access_unit paired with
//               a 1024 x 32 synchronous-read data memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic [31:0] mem_dout;

    logic [31:0] dm [0:1023];
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;

    int checks;
    int errors;

    dm_access_unit #(.WORD_ADDR_W(10), .CHECK_RANGE(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: synchronous read, write port plus a bench backdoor for preloads.
    always @(posedge clk) begin
        if (mem_we)     dm[mem_addr[9:0]] <= mem_din;
        else if (bd_we) dm[bd_addr]       <= bd_data;
        mem_dout <= dm[mem_addr[9:0]];
    end

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = idx; bd_data = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Drive one request, then observe until its response (bounded).
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int wes, output logic [31:0] we_addr, output logic got);
        int wait_cyc;
        rd = 32'd0; er = 1'b0; lat = 0; wes = 0; we_addr = 32'd0; got = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        for (int i = 1; i <= 10 && !got; i++) begin
            if (mem_we) begin
                wes++;
                we_addr = mem_addr;
            end
            if (resp_valid) begin
                got = 1'b1; lat = i; rd = resp_rdata; er = resp_err;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1)    begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0)   begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if (resp_err !== 1'b0)     begin errors++; $display("FAIL reset_resp_err got %b exp 0", resp_err); end
        checks++; if (resp_rdata !== 32'd0)  begin errors++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
        checks++; if (mem_we !== 1'b0)       begin errors++; $display("FAIL reset_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 32'd0)    begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
        checks++; if (mem_din !== 32'd0)     begin errors++; $display("FAIL reset_din got %h exp 0", mem_din); end
        rst = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] rd, wa; logic er, got; int lat, wes;
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, wes, wa, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL sw_timeout no response"); end
        checks++; if (lat !== 2)    begin errors++; $display("FAIL sw_latency got %0d exp 2", lat); end
        checks++; if (wes !== 1)    begin errors++; $display("FAIL sw_we_pulses got %0d exp 1", wes); end
        checks++; if (wa !== 32'd4) begin errors++; $display("FAIL sw_we_addr got %h exp 4", wa); end
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL sw_resp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, wes, wa, got);
        checks++; if (got !== 1'b1 || lat !== 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", rd); end
        checks++; if (er !== 1'b0 || wes !== 0) begin errors++; $display("FAIL lw_err_we got err=%b we=%0d exp 0/0", er, wes); end
    endtask

    task automatic test_subword_store();
        logic [31:0] rd, wa; logic er, got; int lat, wes;
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h1234565A, rd, er, lat, wes, wa, got);
        checks++; if (got !== 1'b1 || lat !== 4) begin errors++; $display("FAIL sb_latency got %0d exp 4", lat); end
        checks++; if (wes !== 1 || wa !== 32'd4) begin errors++; $display("FAIL sb_we got pulses=%0d addr=%h exp 1/4", wes, wa); end
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL sb_resp got err=%b rdata=%h exp 0/0", er, rd); end
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, wes, wa, got);
        checks++; if (rd !== 32'hDE5ABEEF) begin errors++; $display("FAIL sb_readback got %h exp de5abeef", rd); end
    endtask

    task automatic test_extend();
        logic [31:0] rd, wa; logic er, got; int lat, wes;
        preload(10'd8, 32'h000080FF);
        issue(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, rd, er, lat, wes, wa, got);
        checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb_signed got %h exp ffffffff", rd); end
        issue(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, rd, er, lat, wes, wa, got);
        checks++; if (rd !== 32'h000000FF) begin errors++; $display("FAIL lbu got %h exp 000000ff", rd); end
        issue(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd, er, lat, wes, wa, got);
        checks++; if (rd !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_signed got %h exp ffff80ff", rd); end
        issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er, lat, wes, wa, got);
        checks++; if (rd !== 32'h00000000) begin errors++; $display("FAIL lhu_upper got %h exp 00000000", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, wa; logic er, got; int lat, wes;
        logic [31:0] addrs [4] = '{32'h21, 32'h22, 32'h20, 32'h0000_1000};
        logic [1:0]  sizes [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic        wrs   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            issue(wrs[i], sizes[i], 1'b1, addrs[i], 32'hCAFEF00D, rd, er, lat, wes, wa, got);
            checks++;
            if (got !== 1'b1 || er !== 1'b1 || rd !== 32'd0 || lat !== 1 || wes !== 0) begin
                errors++;
                $display("FAIL err_case%0d got got=%b err=%b rdata=%h lat=%0d we=%0d exp 1/1/0/1/0",
                         i, got, er, rd, lat, wes);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] rd, wa; logic er, got; int lat, wes;
        logic bad;
        preload(10'd12, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
        req_addr = 32'h30; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", req_ready); end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid !== 1'b0 || mem_we !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet got activity=%b exp 0", bad); end
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lat, wes, wa, got);
        checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL rst_mid_dm got %h exp 11223344", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ref_mem [16];
        logic        w, sg, exp_err;
        logic [1:0]  sz;
        logic [31:0] a, d, word, exp_rd;
        logic [7:0]  b;
        logic [15:0] h;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = (32'h01020304 * (i + 1)) ^ 32'h8C5A_7E93;
            preload(10'(i), ref_mem[i]);
        end
        @(negedge clk);
        req_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 63));
            d  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b10) a[1:0] = 2'b00;
                if (sz == 2'b01) a[0]   = 1'b0;
            end
            word    = ref_mem[a[5:2]];
            exp_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
            exp_rd  = 32'd0;
            if (exp_err) begin
                lat = 1;
            end else if (!w) begin
                lat = 3;
                b = word[8*a[1:0] +: 8];
                h = word[16*a[1] +: 16];
                if (sz == 2'b00)      exp_rd = sg ? {{24{b[7]}}, b} : {24'd0, b};
                else if (sz == 2'b01) exp_rd = sg ? {{16{h[15]}}, h} : {16'd0, h};
                else                  exp_rd = word;
            end else if (sz == 2'b10) begin
                lat = 2;
                ref_mem[a[5:2]] = d;
            end else begin
                lat = 4;
                if (sz == 2'b00) word[8*a[1:0] +: 8]  = d[7:0];
                else             word[16*a[1] +: 16]  = d[15:0];
                ref_mem[a[5:2]] = word;
            end
            req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready_idle got %b exp 1", n, req_ready); end
            @(posedge clk);
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
                checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b%0d_ready_busy cyc%0d got %b exp 0", n, k, req_ready); end
                checks++; if (resp_valid !== (k == lat)) begin errors++; $display("FAIL b2b%0d_resp_valid cyc%0d got %b exp %b", n, k, resp_valid, (k == lat)); end
                if (k == lat) begin
                    checks++;
                    if (resp_err !== exp_err || resp_rdata !== exp_rd) begin
                        errors++;
                        $display("FAIL b2b%0d_data got err=%b rdata=%h exp err=%b rdata=%h", n, resp_err, resp_rdata, exp_err, exp_rd);
                    end
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] rd, wa; logic er, got; int l, wes;
            issue(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0, rd, er, l, wes, wa, got);
            checks++; if (rd !== ref_mem[i]) begin errors++; $display("FAIL b2b_final_word%0d got %h exp %h", i, rd, ref_mem[i]); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        bd_we = 1'b0; bd_addr = 10'd0; bd_data = 32'd0;
        test_reset();
        test_word();
        test_subword_store();
        test_extend();
        test_errors();
        test_rst_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
